// File: rtl/jtsdram_bank_chk_if.sv
// Bank-port bus between the bank checker (master) and one bank port of
// the SDRAM controller (slave). The checker raises rd/wr with addr and
// wr_data. The controller answers with ack, then with rdy when the
// access completes. data_read is valid in the rdy cycle of a read.
interface jtsdram_bank_chk_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          ack;
  logic          rdy;
  logic [DW-1:0] data_read;

  modport master (
    output addr, rd, wr, wr_data,
    input  ack, rdy, data_read
  );

  modport slave (
    input  addr, rd, wr, wr_data,
    output ack, rdy, data_read
  );
endinterface

// File: rtl/jtsdram_bank_chk.sv
// SDRAM single-bank checker.
// A write pass fills addresses 0 .. 2^AW-1 with a pattern chosen by mode.
// A read pass then compares every word against the same pattern. The
// checker counts mismatches, saturating at all-ones, and keeps the
// address of the first mismatch. Requests are only raised while LVBL is
// high. A request that is already raised stays up through blanking.
// Optional build macro JTSDRAM_BANK_STOP_EN: the first mismatch ends the
// read pass at once.
module jtsdram_bank_chk #(
  parameter int AW   = 22,
  parameter int DW   = 32,
  parameter int REFW = 16,
  parameter int ERRW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LVBL,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [REFW-1:0]  data_ref,
  jtsdram_bank_chk_if.master bus,
  output logic             busy,
  output logic             bad,
  output logic [ERRW-1:0]  err_cnt,
  output logic [AW-1:0]    first_bad,
  output logic             done
);

  localparam int NREP = DW / REFW;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      mode_q;
  logic [REFW-1:0] ref_q;
  logic [15:0]     seed_q, lfsr, lfsr_step, seed_in;
  logic [AW-1:0]   addr_q;
  logic            rd_q, wr_q, pend;
  logic            active, acc_done, last, mism;
  logic            need, issue, pend_nxt;
  logic [REFW-1:0] pat;
  logic [DW-1:0]   exp_word;

  assign active    = (state == WRITE) || (state == READ);
  // ack wins over rdy; the controller never sends both in one cycle.
  assign acc_done  = active && !bus.ack && bus.rdy;
  assign last      = &addr_q;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_in   = (data_ref == '0) ? 16'h0001 : 16'(data_ref);

  assign bus.addr    = addr_q;
  assign bus.rd      = rd_q;
  assign bus.wr      = wr_q;
  assign bus.wr_data = wr_q ? exp_word : '0;
  assign busy        = active;
  assign done        = (state == DONE);

  // Pattern for the current address and the mismatch flag for the read pass.
  // NOTE: every signal assigned in always_comb gets a default first, so no latches are inferred.
  always_comb begin
    pat = ref_q;
    case (mode_q)
      2'd1:    pat = ref_q ^ REFW'(addr_q);
      2'd2:    pat = REFW'(lfsr);
      default: pat = ref_q;
    endcase
    exp_word = {NREP{pat}};
    mism     = acc_done && (state == READ) && (bus.data_read != exp_word);
  end

  // Next-state logic, plus the decision to raise or defer the next request.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (mode == 2'd3) ? READ : WRITE;
    end else begin
      case (state)
        WRITE: if (acc_done && last) state_nxt = READ;
        READ: begin
          if (acc_done && last) state_nxt = DONE;
`ifdef JTSDRAM_BANK_STOP_EN
          if (mism) state_nxt = DONE;
`endif
        end
        default: state_nxt = state;
      endcase
    end
    need     = start || pend || (acc_done && (state_nxt != DONE));
    issue    = need && LVBL && ((state_nxt == WRITE) || (state_nxt == READ));
    pend_nxt = need && !LVBL && ((state_nxt == WRITE) || (state_nxt == READ));
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request handshake: start aborts, ack drops, issue raises the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (start || (active && bus.ack)) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
      if (issue) begin
        rd_q <= (state_nxt == READ);
        wr_q <= (state_nxt == WRITE);
      end
    end
  end

  // Sweep address, pattern generator and mismatch statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      mode_q    <= 2'd0;
      ref_q     <= '0;
      seed_q    <= 16'h0001;
      lfsr      <= 16'h0001;
      bad       <= 1'b0;
      err_cnt   <= '0;
      first_bad <= '0;
    end else if (start) begin
      addr_q    <= '0;
      mode_q    <= mode;
      ref_q     <= data_ref;
      seed_q    <= seed_in;
      lfsr      <= seed_in;
      bad       <= 1'b0;
      err_cnt   <= '0;
      first_bad <= '0;
    end else if (acc_done) begin
      // The address wraps to 0 on its own at the phase change.
      addr_q <= addr_q + AW'(1);
      lfsr   <= last ? seed_q : lfsr_step;
      if (mism) begin
        bad <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
        if (err_cnt == '0) first_bad <= addr_q;
      end
    end
  end

endmodule

// File: doc/jtsdram_bank_chk.md
Name: jtsdram_bank_chk

Overview:
- Parametrised successor to the single-bank read checker. Sweeps one SDRAM bank in two phases: a write pass that fills the bank with a selectable pattern, then a read-back pass that compares every word.
- Adds mismatch counting and capture of the first failing address.
- Sits between the test sequencer (start/mode/data_ref) and one bank port of the SDRAM controller.
- Issues requests only during active video (LVBL high).

Parameters:
- AW, 22, bank word-address width; the sweep covers 0 .. 2^AW-1.
- DW, 32, data width of the read/write bus; must be an integer multiple of REFW.
- REFW, 16, width of data_ref and of the pattern seed.
- ERRW, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- LVBL  in  1  vertical blank, active low; requests are issued only while high
- start  in  1  one-cycle pulse; begins or restarts a test
- mode  in  2  pattern select, sampled on start
- data_ref  in  REFW  pattern constant/seed, sampled on start
- addr  out  AW  current word address
- rd  out  1  read request, held until ack
- wr  out  1  write request, held until ack
- wr_data  out  DW  write data, valid while wr=1
- ack  in  1  controller accepted the request
- rdy  in  1  access complete; data_read valid this cycle on reads
- data_read  in  DW  read data
- busy  out  1  high in WRITE or READ state
- bad  out  1  at least one mismatch since the last start
- err_cnt  out  ERRW  mismatch count, saturating at all-ones
- first_bad  out  AW  address of the first mismatch
- done  out  1  test finished; held until the next start

Behaviour:
- Reset values: addr=0, rd=0, wr=0, wr_data=0, busy=0, bad=0, err_cnt=0, first_bad=0, done=0. State is IDLE, deferred-request flag is clear.
- States and transitions:
  - IDLE -> WRITE on start.
  - IDLE -> READ on start when mode=3 (read-only).
  - WRITE -> READ after rdy at the last address (&addr).
  - READ -> DONE after rdy at the last address.
  - DONE -> as IDLE on start.
- start in any state, including mid-access, aborts the current access and restarts the test:
  - addr=0; bad, err_cnt, first_bad and done are cleared; mode and data_ref are latched.
  - The first request is raised in the next cycle, subject to LVBL.
- Pattern P(addr) is REFW bits wide and replicated DW/REFW times:
  - mode 0: P = data_ref.
  - mode 1: P = data_ref ^ addr[REFW-1:0] (addr zero-extended if AW<REFW).
  - mode 2: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1. Seed is data_ref, or 16'h0001 if data_ref=0. The LFSR advances once per rdy and reloads the seed at the start of each phase. REFW is fixed at 16 for this mode.
  - mode 3: compare against the mode 0 pattern; no write pass.
- Handshake:
  - At most one of rd/wr is high at a time.
  - rd/wr is held until ack; ack clears it on the next edge.
  - rdy completes the access: addr increments, wrapping to 0 at the phase change.
  - ack has priority over rdy in the same cycle; the controller guarantees they never coincide.
- LVBL gating:
  - If rdy arrives while LVBL=0, the next request is deferred.
  - A deferred request is raised on the first cycle with LVBL=1. Latency from LVBL rising to rd/wr is 1 cycle.
  - A request already raised stays high through blanking.
- Compare (READ only): on rdy, if data_read != the expected pattern:
  - bad <= 1;
  - err_cnt increments, saturating at 2^ERRW-1;
  - first_bad <= addr, only if err_cnt was 0.
- done rises one cycle after the final rdy in READ; busy falls in the same cycle.
- rdy/ack outside WRITE/READ are ignored.

Optional Feature:
- Macro: JTSDRAM_BANK_STOP_EN.
- When defined: the first mismatch moves READ -> DONE immediately. done=1 and busy=0 on the next cycle, err_cnt=1, and no further requests are issued.
- When undefined: the read pass always runs to the end of the bank.

Test Plan:
- AW=4, mode 0, data_ref=16'hA5A5, ideal memory -> 16 writes of 32'hA5A5A5A5 then 16 reads; done=1, bad=0, err_cnt=0.
- AW=4, mode 1, data_ref=16'h1000, memory corrupts word 5 -> bad=1, err_cnt=1, first_bad=5, done=1 after addr 15.
- AW=4, mode 3, memory returns 0 for words 3, 7 and 9 -> err_cnt=3, first_bad=3. With JTSDRAM_BANK_STOP_EN: done right after word 3, err_cnt=1, no rd after addr 3.
- LVBL=0 when rdy arrives at addr 2 -> no rd/wr until LVBL rises; the request is raised exactly 1 cycle after LVBL rises, and addr=3 is unchanged meanwhile.
- start pulsed mid-READ at addr 8 with bad=1 -> rd drops, addr=0, bad=0, err_cnt=0, done=0; the write pass restarts.
- ERRW=2, memory always wrong in mode 2 with data_ref=0 (seed 1) -> err_cnt saturates at 3; wr_data for addr 1 is the LFSR value after one step from 1, replicated.
